bin_bbox_extract: RTL and testbench

//  Consumes the binarised pixel stream from the grey/threshold stage (bin plus delayed href/vsync/clken).

---
 rtl/bin_bbox_extract_pkg.sv | 31 +++
 rtl/bin_bbox_extract_if.sv | 28 ++
 rtl/bin_bbox_extract_pixel_coord_counter.sv | 53 +++++
 rtl/bin_bbox_extract.sv | 103 ++++++++++
 tb/tb_bin_bbox_extract.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bin_bbox_extract_pkg.sv
// Shared image geometry, result types and FSM encodings for the binary
// bounding-box extractor and its coordinate counter.
package bin_bbox_extract_pkg;

    localparam int   H_RES       = 640;
    localparam int   V_RES       = 480;
    localparam int   XW          = 10;
    localparam int   YW          = 9;
    localparam int   CW          = 19;
    localparam logic FG_LEVEL    = 1'b0;
    localparam int   EDGE_MARGIN = 8;
    localparam int   MIN_PIXELS  = 64;

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;

    typedef struct packed {
        logic [XW-1:0] x_min;
        logic [XW-1:0] x_max;
        logic [YW-1:0] y_min;
        logic [YW-1:0] y_max;
    } bbox_t;

    // Saturated coordinates (x==H_RES, y==V_RES) fall outside automatically.
    function automatic logic in_window(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (int'(x) >= EDGE_MARGIN) && (int'(x) < H_RES - EDGE_MARGIN) &&
               (int'(y) >= EDGE_MARGIN) && (int'(y) < V_RES - EDGE_MARGIN);
    endfunction

endpackage

// File: rtl/bin_bbox_extract_if.sv
// Binarised pixel stream in, bounding-box result out.
interface bin_bbox_extract_if;
    import bin_bbox_extract_pkg::*;

    logic          bin;
    logic          in_href;
    logic          in_vsync;
    logic          in_clken;
    logic          bbox_valid;
    logic          bbox_empty;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic [CW-1:0] fg_count;
    logic          busy;

    modport master (
        output bin, in_href, in_vsync, in_clken,
        input  bbox_valid, bbox_empty, x_min, x_max, y_min, y_max, fg_count, busy
    );

    modport slave (
        input  bin, in_href, in_vsync, in_clken,
        output bbox_valid, bbox_empty, x_min, x_max, y_min, y_max, fg_count, busy
    );

endinterface

// File: rtl/bin_bbox_extract_pixel_coord_counter.sv
// href/vsync edge detection and saturating x/y position of the current pixel.
module pixel_coord_counter
    import bin_bbox_extract_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          href,
    input  logic          vsync,
    input  logic          clken,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_end,
    output logic          frame_start,
    output logic          frame_end
);

    logic href_d;
    logic vsync_d;
    logic line_has_pix;

    assign line_end    = href_d && !href;
    assign frame_start = !vsync_d && vsync;
    assign frame_end   = vsync_d && !vsync;

    always_ff @(posedge clk) begin
        if (reset) begin
            href_d       <= 1'b0;
            vsync_d      <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_has_pix <= 1'b0;
        end else begin
            href_d  <= href;
            vsync_d <= vsync;
            if (frame_start) begin
                x            <= '0;
                y            <= '0;
                line_has_pix <= 1'b0;
            end else if (line_end) begin
                // Lines that carried no pixels do not advance the row.
                x            <= '0;
                line_has_pix <= 1'b0;
                if (line_has_pix && (y < YW'(V_RES)))
                    y <= y + 1'b1;
            end else if (clken && vsync) begin
                line_has_pix <= 1'b1;
                if (x < XW'(H_RES))
                    x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bin_bbox_extract.sv
// Accumulates the bounding box and count of foreground pixels per frame and
// publishes them with a one-cycle valid pulse when vsync falls.
//
//   state   | meaning
//   S_SYNC  | after reset, wait for vsync low so no partial frame is measured
//   S_IDLE  | between frames, wait for vsync rising
//   S_FRAME | frame active, accumulate box and count
module bin_bbox_extract
    import bin_bbox_extract_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    bin_bbox_extract_if.slave bus
);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_end;
    logic          frame_start;
    logic          frame_end;

    logic [1:0]    state;
    logic          found;
    bbox_t         acc;
    logic [CW-1:0] cnt;
    logic          qualify;
    logic          empty_now;

    pixel_coord_counter u_coord (
        .clk         (clk),
        .reset       (reset),
        .href        (bus.in_href),
        .vsync       (bus.in_vsync),
        .clken       (bus.in_clken),
        .x           (x),
        .y           (y),
        .line_end    (line_end),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    assign qualify   = bus.in_clken && bus.in_vsync && (bus.bin == FG_LEVEL) && in_window(x, y);
    assign empty_now = !found || (cnt < CW'(MIN_PIXELS));
    assign bus.busy  = (state == S_FRAME);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_SYNC;
            found          <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
            bus.bbox_valid <= 1'b0;
            bus.bbox_empty <= 1'b1;
            bus.x_min      <= '0;
            bus.x_max      <= '0;
            bus.y_min      <= '0;
            bus.y_max      <= '0;
            bus.fg_count   <= '0;
        end else begin
            bus.bbox_valid <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (!bus.in_vsync)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (frame_start) begin
                        found <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (frame_end) begin
                        bus.bbox_valid <= 1'b1;
                        bus.bbox_empty <= empty_now;
                        bus.fg_count   <= cnt;
                        bus.x_min      <= empty_now ? '0 : acc.x_min;
                        bus.x_max      <= empty_now ? '0 : acc.x_max;
                        bus.y_min      <= empty_now ? '0 : acc.y_min;
                        bus.y_max      <= empty_now ? '0 : acc.y_max;
                        state          <= S_IDLE;
                    end else if (qualify) begin
                        if (cnt != '1)
                            cnt <= cnt + 1'b1;
                        if (!found) begin
                            found <= 1'b1;
                            acc   <= '{x_min: x, x_max: x, y_min: y, y_max: y};
                        end else begin
                            if (x < acc.x_min) acc.x_min <= x;
                            if (x > acc.x_max) acc.x_max <= x;
                            if (y < acc.y_min) acc.y_min <= y;
                            if (y > acc.y_max) acc.y_max <= y;
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bbox_extract.sv
// Directed frames through bin_bbox_extract with hand-computed box/count results.
`timescale 1ns/1ps
module tb_bin_bbox_extract;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulse_cnt = 0;
    int   exp_pulses = 0;
    int   pulses_before;

    bin_bbox_extract_if bus();

    bin_bbox_extract dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.bbox_valid === 1'b1) pulse_cnt++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic line_px(input int npix, input int fx0, input int fx1);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            bus.in_href  = 1'b1;
            bus.in_clken = 1'b1;
            bus.bin      = (i >= fx0 && i <= fx1) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic line(input int npix, input int fx0, input int fx1);
        line_px(npix, fx0, fx1);
        @(negedge clk);
        bus.in_href  = 1'b0;
        bus.in_clken = 1'b0;
        bus.bin      = 1'b1;
        @(negedge clk);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) line(1, 1, 0);
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.in_vsync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        bus.in_vsync = 1'b0;
        bus.in_href  = 1'b0;
        bus.in_clken = 1'b0;
        bus.bin      = 1'b1;
        exp_pulses++;
        @(negedge clk);
        check_eq({tag, "_valid"}, bus.bbox_valid, 1);
        @(negedge clk);
        check_eq({tag, "_valid_one"}, bus.bbox_valid, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int empty, input int xmin, input int xmax,
                                input int ymin, input int ymax, input int cnt);
        check_eq({tag, "_empty"}, bus.bbox_empty, empty);
        check_eq({tag, "_xmin"},  bus.x_min, xmin);
        check_eq({tag, "_xmax"},  bus.x_max, xmax);
        check_eq({tag, "_ymin"},  bus.y_min, ymin);
        check_eq({tag, "_ymax"},  bus.y_max, ymax);
        check_eq({tag, "_count"}, bus.fg_count, cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.bin      = 1'b1;
        bus.in_href  = 1'b0;
        bus.in_vsync = 1'b0;
        bus.in_clken = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", bus.bbox_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_result("rst", 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // All background: one full-width line, remaining lines short.
        start_frame();
        check_eq("t1_busy", bus.busy, 1);
        line(640, 1, 0);
        blank(479);
        end_frame("t1");
        check_eq("t1_busy_after", bus.busy, 0);
        check_result("t1", 1, 0, 0, 0, 0, 0);

        // 100x100 block; last line drops href together with vsync.
        start_frame();
        blank(50);
        for (int r = 50; r < 149; r++) line(200, 100, 199);
        line_px(200, 100, 199);
        end_frame("t2");
        check_result("t2", 0, 100, 199, 50, 149, 10000);

        // Ink only inside the left and bottom margins.
        start_frame();
        for (int r = 0; r < 472; r++) line(16, 0, 7);
        for (int r = 472; r < 480; r++) line(16, 0, 15);
        end_frame("t3");
        check_result("t3", 1, 0, 0, 0, 0, 0);

        // 30 isolated pixels: counted, but below the minimum.
        start_frame();
        blank(10);
        for (int i = 0; i < 60; i++) begin
            if (i % 2 == 0) line(80, 10 + i, 10 + i);
            else            line(80, 1, 0);
        end
        end_frame("t4");
        check_result("t4", 1, 0, 0, 0, 0, 30);

        // Exactly 64 pixels at the far window corner; x=632 and y=472 are outside.
        start_frame();
        blank(464);
        for (int r = 464; r < 472; r++) line(640, 624, 632);
        line(640, 624, 631);
        end_frame("t4b");
        check_result("t4b", 0, 624, 631, 464, 471, 64);

        // 63 pixels starting at the near window corner.
        start_frame();
        blank(8);
        for (int r = 8; r < 15; r++) line(20, 8, 16);
        end_frame("t4c");
        check_result("t4c", 1, 0, 0, 0, 0, 63);

        // Frame with zero lines.
        start_frame();
        end_frame("t0l");
        check_result("t0l", 1, 0, 0, 0, 0, 0);

        // Reset at line 200: that frame must not report.
        start_frame();
        blank(100);
        for (int r = 100; r < 200; r++) line(40, 20, 30);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_busy", bus.busy, 0);
        check_eq("t5_empty", bus.bbox_empty, 1);
        check_eq("t5_count", bus.fg_count, 0);
        pulses_before = pulse_cnt;
        for (int r = 200; r < 250; r++) line(40, 20, 30);
        @(negedge clk);
        bus.in_vsync = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t5_no_pulse", pulse_cnt - pulses_before, 0);

        start_frame();
        blank(20);
        for (int r = 20; r < 30; r++) line(40, 30, 39);
        end_frame("t5n");
        check_result("t5n", 0, 30, 39, 20, 29, 100);

        // Two consecutive frames; the second contains 700-pixel lines.
        start_frame();
        blank(20);
        for (int r = 20; r < 32; r++) line(60, 50, 59);
        end_frame("t6a");
        check_result("t6a", 0, 50, 59, 20, 31, 120);

        start_frame();
        blank(40);
        for (int r = 40; r < 48; r++) line(700, 600, 699);
        line(700, 20, 21);
        end_frame("t6b");
        check_result("t6b", 0, 20, 631, 40, 48, 258);

        check_eq("pulse_total", pulse_cnt, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
